// File: rtl/serializer_pkg.sv
// Shared encodings and helpers for the parametrised frame serializer.
// Imported by par_calc and param_serializer.
package serializer_pkg;

    localparam logic LSB_FIRST_C = 1'b1;
    localparam logic MSB_FIRST_C = 1'b0;

    localparam logic EVEN_C = 1'b0;
    localparam logic ODD_C  = 1'b1;

    localparam int unsigned MIN_DATA_W = 5;
    localparam int unsigned MAX_DATA_W = 16;

    // Index of the next payload bit for a frame with cnt bits remaining.
    // Only meaningful for cnt != 0.
    function automatic int unsigned bit_index(
        input int unsigned cnt,
        input logic        lsb,
        input int unsigned width
    );
        if (lsb == LSB_FIRST_C)
            return width - cnt;
        else
            return cnt - 1;
    endfunction

endpackage

// File: rtl/par_calc.sv
// Frame parity: XOR of the payload, inverted for odd parity.
// Purely combinational.
module par_calc
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par
);

    logic xor_all;

    assign xor_all = ^data;
    assign par     = (par_typ == ODD_C) ? ~xor_all : xor_all;

endmodule

// File: rtl/param_serializer.sv
// Two-entry parallel-to-serial frame serializer: a shift stage fed
// directly or via a one-frame holding buffer, with per-frame parity.
module param_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  LSB_FIRST,
    input  logic                  PAR_TYP,
    input  logic                  SER_EN,
    output logic                  SER_DATA,
    output logic                  SER_DONE,
    output logic                  PAR_BIT
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    // Shift stage; its parity is the PAR_BIT register itself.
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] sh_data;
    logic                  sh_lsb;
    logic                  ser_q;
    logic                  par_q;

    // Holding buffer; PAR_TYP is folded into the stored parity.
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_lsb;
    logic                  buf_par;
    logic                  buf_full;

    logic                  in_par;
    logic                  accept;
    logic                  sh_empty;
    logic                  shift_en;
    logic                  load_in;
    logic                  promote;
    logic [DATA_WIDTH-1:0] sh_shifted;

    par_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par     (in_par)
    );

    assign sh_empty = (cnt == '0);
    assign accept   = DATA_VALID & ~buf_full;
    assign shift_en = SER_EN & ~sh_empty;
    // Accept needs an empty buffer, so a direct load never meets a promotion.
    assign load_in  = accept & sh_empty;
    assign promote  = sh_empty & ~SER_EN & buf_full;

    assign sh_shifted = sh_data >> bit_index(32'(cnt), sh_lsb, DATA_WIDTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            sh_data <= '0;
            sh_lsb  <= MSB_FIRST_C;
            ser_q   <= 1'b0;
            par_q   <= 1'b0;
        end else if (shift_en) begin
            ser_q <= sh_shifted[0];
            cnt   <= cnt - ONE_CNT;
        end else if (load_in) begin
            sh_data <= P_DATA;
            sh_lsb  <= LSB_FIRST;
            par_q   <= in_par;
            cnt     <= FULL_CNT;
        end else if (promote) begin
            sh_data <= buf_data;
            sh_lsb  <= buf_lsb;
            par_q   <= buf_par;
            cnt     <= FULL_CNT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_data <= '0;
            buf_lsb  <= MSB_FIRST_C;
            buf_par  <= 1'b0;
            buf_full <= 1'b0;
        end else if (accept && !sh_empty) begin
            buf_data <= P_DATA;
            buf_lsb  <= LSB_FIRST;
            buf_par  <= in_par;
            buf_full <= 1'b1;
        end else if (promote) begin
            buf_full <= 1'b0;
        end
    end

    assign DATA_READY = ~buf_full;
    assign SER_DATA   = ser_q;
    assign SER_DONE   = sh_empty;
    assign PAR_BIT    = par_q;

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer at DATA_WIDTH=8.
// Expected bits and parities are queued at accept and popped at output.
module tb_param_serializer;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic          LSB_FIRST;
    logic          PAR_TYP;
    logic          SER_EN;
    logic          SER_DATA;
    logic          SER_DONE;
    logic          PAR_BIT;

    int n_cmp = 0;
    int n_err = 0;
    bit bit_q[$];
    bit par_q[$];
    bit last_bit;

    param_serializer #(
        .DATA_WIDTH (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .LSB_FIRST  (LSB_FIRST),
        .PAR_TYP    (PAR_TYP),
        .SER_EN     (SER_EN),
        .SER_DATA   (SER_DATA),
        .SER_DONE   (SER_DONE),
        .PAR_BIT    (PAR_BIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer a frame that the bench expects to be accepted at the next edge.
    task automatic offer(input logic [DW-1:0] d, input logic lsb,
                         input logic pt);
        chk("ready_at_offer", DATA_READY, 1);
        P_DATA     = d;
        LSB_FIRST  = lsb;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        for (int i = 0; i < DW; i++)
            bit_q.push_back(lsb ? d[i] : d[DW-1-i]);
        par_q.push_back((^d) ^ pt);
    endtask

    task automatic shift_chk(input string tag);
        bit e;
        tick();
        if (bit_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0b with scoreboard empty", tag, SER_DATA);
        end else begin
            e = bit_q.pop_front();
            chk(tag, SER_DATA, e);
            last_bit = e;
        end
    endtask

    task automatic par_chk(input string tag);
        if (par_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0b with parity queue empty", tag, PAR_BIT);
        end else begin
            chk(tag, PAR_BIT, par_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          rl;
        logic          rp;

        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        LSB_FIRST  = 1'b1;
        PAR_TYP    = 1'b0;
        SER_EN     = 1'b0;
        last_bit   = 1'b0;

        tick();
        tick();
        RST = 1'b0;
        chk("rst_ser", SER_DATA, 0);
        chk("rst_done", SER_DONE, 1);
        chk("rst_ready", DATA_READY, 1);
        chk("rst_par", PAR_BIT, 0);

        // LSB first, even parity
        offer(8'hD2, 1'b1, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        chk("lsb_done_fall", SER_DONE, 0);
        par_chk("lsb_par");
        SER_EN = 1'b1;
        repeat (DW) shift_chk("lsb_bit");
        chk("lsb_done", SER_DONE, 1);
        SER_EN = 1'b0;

        // MSB first, odd parity
        offer(8'hD2, 1'b0, 1'b1);
        tick();
        DATA_VALID = 1'b0;
        par_chk("msb_par");
        SER_EN = 1'b1;
        repeat (DW) shift_chk("msb_bit");
        chk("msb_done", SER_DONE, 1);
        SER_EN = 1'b0;

        // Back-to-back through the holding buffer
        offer(8'hD2, 1'b1, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        par_chk("b2b_par0");
        SER_EN = 1'b1;
        offer(8'h0F, 1'b1, 1'b0);
        shift_chk("b2b_bit0");
        DATA_VALID = 1'b0;
        chk("b2b_ready_full", DATA_READY, 0);
        P_DATA     = 8'hAA;
        LSB_FIRST  = 1'b0;
        PAR_TYP    = 1'b1;
        DATA_VALID = 1'b1;
        shift_chk("b2b_bit0");
        DATA_VALID = 1'b0;
        chk("b2b_ignored", DATA_READY, 0);
        repeat (DW - 2) shift_chk("b2b_bit0");
        chk("b2b_done0", SER_DONE, 1);
        chk("b2b_ready_hold", DATA_READY, 0);
        SER_EN = 1'b0;
        tick();
        chk("promo_ready", DATA_READY, 1);
        chk("promo_done", SER_DONE, 0);
        par_chk("promo_par");
        SER_EN = 1'b1;
        repeat (DW) shift_chk("b2b_bit1");
        chk("b2b_done1", SER_DONE, 1);

        // Idle enable holds the last bit
        repeat (5) begin
            tick();
            chk("idle_ser", SER_DATA, last_bit);
            chk("idle_done", SER_DONE, 1);
        end
        SER_EN = 1'b0;

        // Reset mid-frame with the buffer full
        offer(8'hA5, 1'b0, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        par_chk("mid_par");
        offer(8'h3C, 1'b1, 1'b1);
        tick();
        DATA_VALID = 1'b0;
        chk("mid_ready_full", DATA_READY, 0);
        SER_EN = 1'b1;
        repeat (3) shift_chk("mid_bit");
        RST = 1'b1;
        tick();
        RST    = 1'b0;
        SER_EN = 1'b0;
        chk("mid_rst_ser", SER_DATA, 0);
        chk("mid_rst_par", PAR_BIT, 0);
        chk("mid_rst_done", SER_DONE, 1);
        chk("mid_rst_ready", DATA_READY, 1);
        bit_q.delete();
        par_q.delete();
        tick();
        chk("mid_no_promo", SER_DONE, 1);
        SER_EN = 1'b1;
        repeat (4) begin
            tick();
            chk("mid_resid_ser", SER_DATA, 0);
            chk("mid_resid_done", SER_DONE, 1);
        end
        SER_EN = 1'b0;

        // Assorted frames
        for (int k = 0; k < 4; k++) begin
            rd = DW'($urandom);
            rl = 1'($urandom_range(0, 1));
            rp = 1'($urandom_range(0, 1));
            offer(rd, rl, rp);
            tick();
            DATA_VALID = 1'b0;
            par_chk("rnd_par");
            SER_EN = 1'b1;
            repeat (DW) shift_chk("rnd_bit");
            chk("rnd_done", SER_DONE, 1);
            SER_EN = 1'b0;
            tick();
        end

        chk("sb_empty", bit_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning frame payload bits, legal range 5..16.
REQ-002 The block SHALL have parameter CNT_WIDTH, default $clog2(DATA_WIDTH+1), meaning bit-counter width, derived and not overridden.
REQ-003 The block SHALL have port CLK, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port P_DATA, input, DATA_WIDTH, meaning the parallel frame payload.
REQ-006 The block SHALL have port DATA_VALID, input, 1, meaning P_DATA is offered.
REQ-007 The block SHALL have port DATA_READY, output, 1, meaning the block can accept a frame this cycle.
REQ-008 The block SHALL have port LSB_FIRST, input, 1, meaning bit order: 1 = LSB first, 0 = MSB first; captured with the frame.
REQ-009 The block SHALL have port PAR_TYP, input, 1, meaning parity type: 0 = even, 1 = odd; captured with the frame.
REQ-010 The block SHALL have port SER_EN, input, 1, meaning shift one bit this cycle.
REQ-011 The block SHALL have port SER_DATA, output, 1, meaning the registered serial bit.
REQ-012 The block SHALL have port SER_DONE, output, 1, meaning the active frame has no bits left; combinational from the counter.
REQ-013 The block SHALL have port PAR_BIT, output, 1, meaning the registered parity of the active frame.

Function
REQ-014 Storage SHALL be two entries, a shift stage and a holding buffer, each holding data, LSB_FIRST, PAR_TYP and parity.
REQ-015 DATA_READY SHALL equal NOT(holding buffer full); it SHALL be independent of DATA_VALID.
REQ-016 A frame SHALL be accepted on a cycle where DATA_VALID=1 and DATA_READY=1; DATA_VALID while DATA_READY=0 SHALL be ignored.
REQ-017 On accept with the shift stage empty (counter=0) and no promotion pending, the frame SHALL load directly into the shift stage with counter=DATA_WIDTH; SER_DONE SHALL fall the next cycle.
REQ-018 On accept with the shift stage occupied, the frame SHALL go to the holding buffer; DATA_READY SHALL fall the next cycle.
REQ-019 Parity SHALL be computed from P_DATA at accept: XOR of all bits, XOR PAR_TYP.
REQ-020 With SER_EN=1 and counter!=0, SER_DATA SHALL take the next bit (index DATA_WIDTH-counter if LSB first, counter-1 if MSB first) and counter SHALL decrement, so one bit is produced per enabled cycle.
REQ-021 With SER_EN=1 and counter=0, SER_DATA and counter SHALL hold; the counter SHALL never wrap.
REQ-022 Promotion: when counter=0, SER_EN=0 and the buffer is full, the buffer SHALL move to the shift stage (counter=DATA_WIDTH).
REQ-023 After a promotion, the buffer SHALL be empty and DATA_READY SHALL rise the next cycle.
REQ-024 An accept in the promotion cycle is impossible, because DATA_READY=0.
REQ-025 PAR_BIT SHALL update when a frame enters the shift stage and hold until the next entry.
REQ-026 SER_DONE SHALL be high for at least one cycle between consecutive frames.

Reset
REQ-027 With RST=1 at a clock edge, the block SHALL set SER_DATA=0, PAR_BIT=0, counter=0 (SER_DONE=1), buffer empty (DATA_READY=1), and stored data to 0.
REQ-028 Reset SHALL override all other inputs, including mid-frame, discarding both the shift stage and the buffer.

Structure
REQ-029 The shared package serializer_pkg SHALL hold the bit-order encodings (LSB_FIRST_C=1, MSB_FIRST_C=0) and the parity encodings (EVEN_C=0, ODD_C=1).
REQ-030 The parity computation SHALL be a sub-module, par_calc, parametrised by DATA_WIDTH.

Verification (DATA_WIDTH=8)
REQ-031 Reset: RST=1 for 2 cycles -> SER_DATA=0, SER_DONE=1, DATA_READY=1, PAR_BIT=0.
REQ-032 LSB-first: accept 0xD2, PAR_TYP=0, then SER_EN=1 for 8 cycles -> SER_DATA 0,1,0,0,1,0,1,1; PAR_BIT=0; SER_DONE=1 after the 8th shift.
REQ-033 MSB-first: accept 0xD2, PAR_TYP=1 -> SER_DATA 1,1,0,1,0,0,1,0; PAR_BIT=1.
REQ-034 Back-to-back: accept 0xD2, then 0x0F during shifting -> DATA_READY=0; after the last bit, SER_EN=0 promotes 0x0F; DATA_READY=1 the next cycle; the second frame shifts 1,1,1,1,0,0,0,0 (LSB first).
REQ-035 Idle enable: SER_EN=1 with counter=0 for 5 cycles -> SER_DATA holds its last value and SER_DONE stays 1.
REQ-036 Reset mid-frame: RST=1 after 3 shifts with the buffer full -> reset values next cycle, and no residual bits when SER_EN is then asserted.
